// File: rtl/leg_branch_sequencer.sv
// LEG core PC and instruction-fetch sequencer: fetches 4-byte instructions over a
// byte-wide req/ack port, presents them downstream and selects the next PC.
module leg_branch_sequencer #(
   parameter logic [7:0]  RESET_PC   = 8'h00,
   parameter int unsigned INSN_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_data,
   output logic       insn_valid,
   input  logic       insn_ready,
   output logic [7:0] OPCODE,
   output logic [7:0] ARG1,
   output logic [7:0] ARG2,
   output logic [7:0] DEST,
   input  logic       cond_result,
   output logic [7:0] pc,
   output logic       is_branch
);

   localparam int unsigned AW = 8;
   localparam int unsigned IW = 2;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t        state;
   logic [IW-1:0] byte_idx;
   logic          last_byte;
   logic          take_branch;

   // Address math is 8-bit; carries out of bit 7 are dropped
   assign mem_addr    = pc + AW'(byte_idx);
   // Bits 7:6 of the opcode are immediate flags and do not affect the class
   assign is_branch   = (OPCODE[5:0] >= 6'h20) && (OPCODE[5:0] <= 6'h25);
   assign last_byte   = (byte_idx == IW'(INSN_BYTES - 1));
   assign take_branch = is_branch && cond_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         byte_idx   <= '0;
         mem_req    <= 1'b0;
         insn_valid <= 1'b0;
         OPCODE     <= '0;
         ARG1       <= '0;
         ARG2       <= '0;
         DEST       <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (!mem_req) begin
                  mem_req <= 1'b1;
               end else if (mem_ack) begin
                  // Instruction registers are overwritten in place, never cleared
                  case (byte_idx)
                     2'd0: OPCODE <= mem_data;
                     2'd1: ARG1   <= mem_data;
                     2'd2: ARG2   <= mem_data;
                     2'd3: DEST   <= mem_data;
                  endcase
                  if (last_byte) begin
                     mem_req    <= 1'b0;
                     insn_valid <= 1'b1;
                     byte_idx   <= '0;
                     state      <= ISSUE;
                  end else begin
                     byte_idx <= byte_idx + IW'(1);
                  end
               end
            end
            ISSUE: begin
               if (insn_ready) begin
                  pc         <= take_branch ? DEST : pc + AW'(INSN_BYTES);
                  insn_valid <= 1'b0;
                  byte_idx   <= '0;
                  mem_req    <= 1'b1;
                  state      <= FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leg_branch_sequencer.sv
// Directed bench for leg_branch_sequencer: fetch, branch selection, wrap-around,
// memory gaps, downstream backpressure and mid-flight reset.
module tb_leg_branch_sequencer;

   logic       clk = 1'b0;
   logic       rst, rst_w;
   logic       ack_auto, ack_force;
   logic       insn_ready, cond_result;
   logic [7:0] mem [256];

   logic       mem_req, mem_ack, insn_valid, is_branch;
   logic [7:0] mem_addr, mem_data, opcode, arg1, arg2, dest, pc;

   logic       mem_req_w, mem_ack_w, insn_valid_w, is_branch_w;
   logic [7:0] mem_addr_w, mem_data_w, opcode_w, arg1_w, arg2_w, dest_w, pc_w;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mem_data   = mem[mem_addr];
   assign mem_data_w = mem[mem_addr_w];
   assign mem_ack    = ack_force | (ack_auto & mem_req);
   assign mem_ack_w  = ack_auto & mem_req_w;

   leg_branch_sequencer #(.RESET_PC(8'h00), .INSN_BYTES(4)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .insn_valid(insn_valid),
      .insn_ready(insn_ready), .OPCODE(opcode), .ARG1(arg1), .ARG2(arg2),
      .DEST(dest), .cond_result(cond_result), .pc(pc), .is_branch(is_branch)
   );

   leg_branch_sequencer #(.RESET_PC(8'hFC), .INSN_BYTES(4)) dut_w (
      .clk(clk), .rst(rst_w), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
      .mem_ack(mem_ack_w), .mem_data(mem_data_w), .insn_valid(insn_valid_w),
      .insn_ready(insn_ready), .OPCODE(opcode_w), .ARG1(arg1_w), .ARG2(arg2_w),
      .DEST(dest_w), .cond_result(cond_result), .pc(pc_w), .is_branch(is_branch_w)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!insn_valid && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(insn_valid), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; insn_ready = 1'b0; cond_result = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic handshake(input logic cr);
      cond_result = cr; insn_ready = 1'b1;
      step();
      insn_ready = 1'b0; cond_result = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst = 1'b1; rst_w = 1'b1; ack_auto = 1'b1; ack_force = 1'b0;
      insn_ready = 1'b0; cond_result = 1'b0;

      // 1: reset values and a plain fetch
      mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
      step();
      check("rst_pc", 32'(pc), 32'h00);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_valid", 32'(insn_valid), 32'd0);
      check("rst_opcode", 32'(opcode), 32'h00);
      rst = 1'b0;
      step();
      check("t1_req", 32'(mem_req), 32'd1);
      check("t1_addr0", 32'(mem_addr), 32'h00);
      step();
      check("t1_addr1", 32'(mem_addr), 32'h01);
      wait_valid("t1_valid");
      check("t1_insn", {opcode, arg1, arg2, dest}, 32'h00112233);
      check("t1_req_low", 32'(mem_req), 32'd0);
      handshake(1'b1);
      check("t1_pc", 32'(pc), 32'h04);
      check("t1_valid_low", 32'(insn_valid), 32'd0);
      check("t1_refetch", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h04});

      // 2: conditional branch taken
      mem[0] = 8'h20; mem[1] = 8'h05; mem[2] = 8'h05; mem[3] = 8'h40;
      do_reset();
      wait_valid("t2_valid");
      check("t2_is_branch", 32'(is_branch), 32'd1);
      check("t2_dest", 32'(dest), 32'h40);
      handshake(1'b1);
      check("t2_pc", 32'(pc), 32'h40);
      check("t2_addr", 32'(mem_addr), 32'h40);

      // 3: branch with immediate flags not taken; non-branch ignores cond_result
      mem[0] = 8'hE2; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h80;
      mem[4] = 8'h26; mem[5] = 8'h03; mem[6] = 8'h04; mem[7] = 8'h90;
      do_reset();
      wait_valid("t3a_valid");
      check("t3a_is_branch", 32'(is_branch), 32'd1);
      handshake(1'b0);
      check("t3a_pc", 32'(pc), 32'h04);
      wait_valid("t3b_valid");
      check("t3b_is_branch", 32'(is_branch), 32'd0);
      handshake(1'b1);
      check("t3b_pc", 32'(pc), 32'h08);

      // 5: ack gaps, backpressure, spurious ack
      mem[8] = 8'hA1; mem[9] = 8'hB2; mem[10] = 8'hC3; mem[11] = 8'hD4;
      step();
      ack_auto = 1'b0;
      step(); step(); step();
      check("t5_gap_opcode", 32'(opcode), 32'hA1);
      check("t5_gap_addr", 32'(mem_addr), 32'h09);
      check("t5_gap_req", 32'(mem_req), 32'd1);
      ack_auto = 1'b1;
      wait_valid("t5_valid");
      check("t5_insn", {opcode, arg1, arg2, dest}, 32'hA1B2C3D4);
      ack_force = 1'b1; cond_result = 1'b1;
      for (int i = 0; i < 5; i++) step();
      ack_force = 1'b0; cond_result = 1'b0;
      check("t5_hold_valid", 32'(insn_valid), 32'd1);
      check("t5_hold_insn", {opcode, arg1, arg2, dest}, 32'hA1B2C3D4);
      check("t5_hold_pc", 32'(pc), 32'h08);
      check("t5_hold_req", 32'(mem_req), 32'd0);
      handshake(1'b0);
      check("t5_pc", 32'(pc), 32'h0C);

      // 6: reset after two bytes, with an ack pending
      mem[12] = 8'h55; mem[13] = 8'h66; mem[14] = 8'h77; mem[15] = 8'h88;
      step(); step();
      check("t6_mid_arg1", 32'(arg1), 32'h66);
      rst = 1'b1;
      step();
      check("t6_pc", 32'(pc), 32'h00);
      check("t6_req", 32'(mem_req), 32'd0);
      check("t6_valid", 32'(insn_valid), 32'd0);
      check("t6_opcode", 32'(opcode), 32'h00);
      rst = 1'b0;
      step();
      check("t6_refetch", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, 8'h00});
      wait_valid("t6_valid_again");
      check("t6_insn", {opcode, arg1, arg2, dest}, 32'hE2010280);
      rst = 1'b1;
      step();
      check("t6_issue_rst_valid", 32'(insn_valid), 32'd0);
      check("t6_issue_rst_pc", 32'(pc), 32'h00);

      // 4: wrap-around on the RESET_PC=FC instance (primary held in reset)
      mem[252] = 8'h01; mem[253] = 8'h02; mem[254] = 8'h03; mem[255] = 8'h04;
      mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hFE;
      rst_w = 1'b0;
      step();
      check("t4_addr_fc", 32'(mem_addr_w), 32'hFC);
      step();
      check("t4_addr_fd", 32'(mem_addr_w), 32'hFD);
      step();
      check("t4_addr_fe", 32'(mem_addr_w), 32'hFE);
      step();
      check("t4_addr_ff", 32'(mem_addr_w), 32'hFF);
      step();
      check("t4_valid", 32'(insn_valid_w), 32'd1);
      check("t4_pc_fc", 32'(pc_w), 32'hFC);
      handshake(1'b1);
      check("t4_pc_wrap", 32'(pc_w), 32'h00);
      step(); step(); step(); step();
      check("t4_br_valid", 32'(insn_valid_w), 32'd1);
      check("t4_br_is_branch", 32'(is_branch_w), 32'd1);
      handshake(1'b1);
      check("t4_pc_fe", 32'(pc_w), 32'hFE);
      check("t4_wrap_addr0", 32'(mem_addr_w), 32'hFE);
      step();
      check("t4_wrap_addr1", 32'(mem_addr_w), 32'hFF);
      step();
      check("t4_wrap_addr2", 32'(mem_addr_w), 32'h00);
      step();
      check("t4_wrap_addr3", 32'(mem_addr_w), 32'h01);
      step();
      check("t4_wrap_valid", 32'(insn_valid_w), 32'd1);
      check("t4_wrap_insn", {opcode_w, arg1_w, arg2_w, dest_w}, 32'h03042000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
